// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default sizing, thresholds and
// pointer helpers. Pointers carry one extra wrap bit above the RAM address.
package fifo_pkg;

   localparam int DATA_LEN_DEF  = 32;
   localparam int ADDR_LEN_DEF  = 8;
   localparam int AFULL_TH_DEF  = (1 << ADDR_LEN_DEF) - 4;
   localparam int AEMPTY_TH_DEF = 4;

   // Mask selecting the ADDR_LEN+1 meaningful pointer bits.
   function automatic logic [31:0] ptr_mask(input int addr_len);
      return (32'd1 << (addr_len + 1)) - 32'd1;
   endfunction

   // Occupancy between two wrap-bit pointers, modulo 2*DEPTH.
   function automatic logic [31:0] ptr_count(input logic [31:0] wptr,
                                             input logic [31:0] rptr,
                                             input int addr_len);
      return (wptr - rptr) & ptr_mask(addr_len);
   endfunction

   // Full: same address bits, opposite wrap bit.
   function automatic logic ptr_full(input logic [31:0] wptr,
                                     input logic [31:0] rptr,
                                     input int addr_len);
      return ((wptr ^ rptr) & ptr_mask(addr_len)) == (32'd1 << addr_len);
   endfunction

   // Empty: pointers identical including wrap bit.
   function automatic logic ptr_empty(input logic [31:0] wptr,
                                      input logic [31:0] rptr,
                                      input int addr_len);
      return ((wptr ^ rptr) & ptr_mask(addr_len)) == 32'd0;
   endfunction

endpackage

// File: rtl/fifo_mem_sync.sv
// DEPTH x DATA_LEN dual-port RAM: synchronous write, registered read with
// read enable. Only the read register is reset; the array is not.
module fifo_mem_sync #(
   parameter int DATA_LEN = 32,
   parameter int ADDR_LEN = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_we,
   input  logic [ADDR_LEN-1:0] i_waddr,
   input  logic [DATA_LEN-1:0] i_wdata,
   input  logic                i_re,
   input  logic [ADDR_LEN-1:0] i_raddr,
   output logic [DATA_LEN-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_LEN;

   logic [DATA_LEN-1:0] r_mem [DEPTH];
   logic [DATA_LEN-1:0] r_rdata;

   // Write port: store on write enable.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read port: capture on read enable, otherwise hold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags, sticky
// error bits and an optional first-word-fall-through stage. In FWFT mode the
// RAM read register doubles as the output register and is counted in count_o.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_LEN  = DATA_LEN_DEF,
   parameter int ADDR_LEN  = ADDR_LEN_DEF,
   parameter int AFULL_TH  = (1 << ADDR_LEN) - 4,
   parameter int AEMPTY_TH = AEMPTY_TH_DEF,
   parameter bit FWFT      = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                wen_i,
   input  logic [DATA_LEN-1:0] wdata_i,
   input  logic                ren_i,
   output logic [DATA_LEN-1:0] rdata_o,
   output logic                rvalid_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                afull_o,
   output logic                aempty_o,
   output logic [ADDR_LEN:0]   count_o,
   output logic                ovf_o,
   output logic                udf_o
);

   localparam int DEPTH = 1 << ADDR_LEN;
   localparam int PW    = ADDR_LEN + 1;

   if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_thresholds
      $error("sync_fifo_ctrl: require AEMPTY_TH < AFULL_TH <= DEPTH");
   end

   logic [PW-1:0] r_wptr, r_rptr, r_count;
   logic          r_full, r_empty, r_afull, r_aempty;
   logic          r_rvalid, r_ovf, r_udf;

   logic          w_wr_acc, w_rd_acc, w_ram_re, w_ram_has;
   logic [PW-1:0] w_wptr_nxt, w_rptr_nxt, w_count_nxt;
   logic          w_rvalid_nxt, w_empty_nxt, w_full_nxt;

   // Acceptance, RAM read scheduling and next-state pointers/flags.
   always_comb begin
      w_wr_acc  = wen_i & ~r_full  & ~flush_i;
      w_rd_acc  = ren_i & ~r_empty & ~flush_i;
      w_ram_has = ~ptr_empty(32'(r_wptr), 32'(r_rptr), ADDR_LEN);
      w_ram_re  = w_rd_acc;
      w_rvalid_nxt = w_rd_acc;
      if (FWFT) begin
         // Refill the output register whenever it is free or being popped.
         w_ram_re     = w_ram_has & (~r_rvalid | w_rd_acc) & ~flush_i;
         w_rvalid_nxt = w_ram_re | (r_rvalid & ~w_rd_acc);
      end
      w_wptr_nxt  = r_wptr + PW'(w_wr_acc);
      w_rptr_nxt  = r_rptr + PW'(w_ram_re);
      w_count_nxt = r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
      if (FWFT) begin
         w_empty_nxt = ~w_rvalid_nxt;
         w_full_nxt  = (w_count_nxt == PW'(DEPTH));
      end else begin
         w_empty_nxt = ptr_empty(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_LEN);
         w_full_nxt  = ptr_full(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_LEN);
      end
   end

   // State and flag registers; flush clears everything except read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_rvalid <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (flush_i) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
         r_rvalid <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wptr   <= w_wptr_nxt;
         r_rptr   <= w_rptr_nxt;
         r_count  <= w_count_nxt;
         r_full   <= w_full_nxt;
         r_empty  <= w_empty_nxt;
         r_afull  <= (32'(w_count_nxt) >= AFULL_TH);
         r_aempty <= (32'(w_count_nxt) <= AEMPTY_TH);
         r_rvalid <= w_rvalid_nxt;
         r_ovf    <= r_ovf | (wen_i & r_full);
         r_udf    <= r_udf | (ren_i & r_empty);
      end
   end

   fifo_mem_sync #(
      .DATA_LEN (DATA_LEN),
      .ADDR_LEN (ADDR_LEN)
   ) u_mem (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr[ADDR_LEN-1:0]),
      .i_wdata (wdata_i),
      .i_re    (w_ram_re),
      .i_raddr (r_rptr[ADDR_LEN-1:0]),
      .o_rdata (rdata_o)
   );

   assign rvalid_o = r_rvalid;
   assign full_o   = r_full;
   assign empty_o  = r_empty;
   assign afull_o  = r_afull;
   assign aempty_o = r_aempty;
   assign count_o  = r_count;
   assign ovf_o    = r_ovf;
   assign udf_o    = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench: one standard-read instance and one FWFT instance.
module tb_sync_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        flush, wen, ren;
   logic [31:0] wdata, rdata;
   logic        rvalid, full, empty, afull, aempty, ovf, udf;
   logic [8:0]  count;

   logic        f_flush, f_wen, f_ren;
   logic [31:0] f_wdata, f_rdata;
   logic        f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [8:0]  f_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.FWFT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .flush_i(flush), .wen_i(wen), .wdata_i(wdata),
      .ren_i(ren), .rdata_o(rdata), .rvalid_o(rvalid), .full_o(full),
      .empty_o(empty), .afull_o(afull), .aempty_o(aempty), .count_o(count),
      .ovf_o(ovf), .udf_o(udf)
   );

   sync_fifo_ctrl #(.FWFT(1'b1)) u_dut_f (
      .clk(clk), .rst(rst), .flush_i(f_flush), .wen_i(f_wen), .wdata_i(f_wdata),
      .ren_i(f_ren), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full),
      .empty_o(f_empty), .afull_o(f_afull), .aempty_o(f_aempty), .count_o(f_count),
      .ovf_o(f_ovf), .udf_o(f_udf)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      flush = 0; wen = 0; ren = 0; wdata = '0;
      f_flush = 0; f_wen = 0; f_ren = 0; f_wdata = '0;

      // ---------------- reset state ----------------
      step(); step();
      chk("rst_empty",  empty,  1);
      chk("rst_aempty", aempty, 1);
      chk("rst_full",   full,   0);
      chk("rst_afull",  afull,  0);
      chk("rst_count",  count,  0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_ovf",    ovf,    0);
      chk("rst_udf",    udf,    0);
      chk("rst_rdata",  rdata,  0);
      chk("rst_f_empty", f_empty, 1);
      rst = 0;

      // ---------------- 16 writes then 16 reads ----------------
      for (int i = 1; i <= 16; i++) begin
         wen = 1; wdata = 32'hA5A5_0000 + 32'(i);
         step();
         if (i == 1) begin
            chk("wr1_empty", empty, 0);
            chk("wr1_count", count, 1);
         end
      end
      wen = 0;
      chk("wr16_count",  count,  16);
      chk("wr16_aempty", aempty, 0);
      for (int i = 1; i <= 16; i++) begin
         ren = 1;
         step();
         chk("rd_rvalid", rvalid, 1);
         chk("rd_data",   rdata,  32'hA5A5_0000 + 32'(i));
      end
      ren = 0;
      step();
      chk("rd_idle_rvalid", rvalid, 0);
      chk("rd_idle_hold",   rdata,  32'hA5A5_0010);
      chk("rd_done_empty",  empty,  1);
      chk("rd_done_count",  count,  0);

      // ---------------- underflow, then flush ----------------
      ren = 1; step(); ren = 0;
      chk("udf_set",   udf,   1);
      chk("udf_count", count, 0);
      flush = 1; step(); flush = 0;
      chk("flush_udf",   udf,   0);
      chk("flush_rdata", rdata, 32'hA5A5_0010);

      // ---------------- fill to DEPTH ----------------
      for (int i = 0; i < 256; i++) begin
         wen = 1; wdata = 32'h0000_0100 + 32'(i);
         step();
         if (i + 1 == 4)   chk("c4_aempty",   aempty, 1);
         if (i + 1 == 5)   chk("c5_aempty",   aempty, 0);
         if (i + 1 == 251) chk("c251_afull",  afull,  0);
         if (i + 1 == 252) chk("c252_afull",  afull,  1);
         if (i + 1 == 255) chk("c255_full",   full,   0);
      end
      chk("c256_full",  full,  1);
      chk("c256_count", count, 256);
      chk("c256_ovf",   ovf,   0);
      wdata = 32'hBAD0_0000; step();
      chk("ovf_set",   ovf,   1);
      chk("ovf_count", count, 256);

      // full + simultaneous read/write: read wins, write dropped
      ren = 1; wdata = 32'hBAD0_0001; step();
      wen = 0; ren = 0;
      chk("rw_full_count",  count,  255);
      chk("rw_full_full",   full,   0);
      chk("rw_full_ovf",    ovf,    1);
      chk("rw_full_rvalid", rvalid, 1);
      chk("rw_full_rdata",  rdata,  32'h0000_0100);

      // ---------------- reset mid-traffic ----------------
      flush = 1; step(); flush = 0;
      chk("flush_ovf", ovf, 0);
      ren = 1; step(); ren = 0;
      for (int i = 0; i < 5; i++) begin
         wen = 1; wdata = 32'h5500_0000 + 32'(i); step();
      end
      wen = 0;
      chk("pre_rst_count", count, 5);
      chk("pre_rst_udf",   udf,   1);
      rst = 1; #1;
      chk("async_rst_empty", empty, 1);
      chk("async_rst_count", count, 0);
      chk("async_rst_udf",   udf,   0);
      chk("async_rst_ovf",   ovf,   0);
      rst = 0;

      // ---------------- pointer wrap at count=1 ----------------
      wen = 1; wdata = 32'h1000_0000; step();
      for (int k = 0; k < 300; k++) begin
         wen = 1; ren = 1; wdata = 32'h1000_0000 + 32'(k + 1);
         step();
         chk("wrap_data",  rdata, 32'h1000_0000 + 32'(k));
         chk("wrap_count", count, 1);
      end
      wen = 0; ren = 0; step();
      chk("wrap_ovf",   ovf,   0);
      chk("wrap_udf",   udf,   0);
      chk("wrap_full",  full,  0);
      chk("wrap_empty", empty, 0);

      // ---------------- FWFT instance ----------------
      f_flush = 1; step(); f_flush = 0;
      f_wen = 1; f_wdata = 32'hDEAD_BEEF; step(); f_wen = 0;
      chk("f_wr_count", f_count, 1);
      chk("f_wr_empty", f_empty, 1);
      step();
      chk("f_head_data",   f_rdata,  32'hDEAD_BEEF);
      chk("f_head_empty",  f_empty,  0);
      chk("f_head_rvalid", f_rvalid, 1);
      f_ren = 1; step();
      chk("f_pop_empty", f_empty, 1);
      chk("f_pop_count", f_count, 0);
      step(); f_ren = 0;
      chk("f_udf_set", f_udf, 1);
      f_flush = 1; step(); f_flush = 0;
      chk("f_flush_count", f_count, 0);
      chk("f_flush_udf",   f_udf,   0);

      // no-bubble prefetch: three words, three back-to-back pops
      f_wen = 1; f_wdata = 32'h11; step();
      f_wdata = 32'h22; step();
      f_wdata = 32'h33; step();
      f_wen = 0;
      chk("f3_count", f_count, 3);
      chk("f3_head",  f_rdata, 32'h11);
      f_ren = 1; step();
      chk("f3_pop1_data",  f_rdata, 32'h22);
      chk("f3_pop1_count", f_count, 2);
      step();
      chk("f3_pop2_data",  f_rdata, 32'h33);
      chk("f3_pop2_empty", f_empty, 0);
      step(); f_ren = 0;
      chk("f3_pop3_empty", f_empty, 1);
      chk("f3_pop3_count", f_count, 0);
      chk("f3_pop3_udf",   f_udf,   0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
